// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: dif = a - b, one bit per clock, LSB first.
// Each bit passes through two chained half-subtractor stages; a flip-flop carries the borrow between bits.
module serial_subtractor #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] dif,
    output logic             br,
    output logic             ovf
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t             state_reg;
    logic [WIDTH-1:0]   sa_reg;
    logic [WIDTH-1:0]   sb_reg;
    logic [WIDTH-1:0]   res_reg;
    logic               borrow_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic               a_msb_reg;
    logic               b_msb_reg;

    logic               x, y, d1, b1, d, b2, bout;
    logic [WIDTH-1:0]   res_next;

    // Stage 1 subtracts the operand bits; stage 2 subtracts the incoming borrow.
    always_comb begin
        x        = sa_reg[0];
        y        = sb_reg[0];
        d1       = x ^ y;
        b1       = ~x & y;
        d        = d1 ^ borrow_reg;
        b2       = ~d1 & borrow_reg;
        bout     = b1 | b2;
        res_next = {d, res_reg[WIDTH-1:1]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= IDLE;
            sa_reg     <= '0;
            sb_reg     <= '0;
            res_reg    <= '0;
            borrow_reg <= 1'b0;
            cnt_reg    <= '0;
            a_msb_reg  <= 1'b0;
            b_msb_reg  <= 1'b0;
            dif        <= '0;
            br         <= 1'b0;
            ovf        <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        sa_reg     <= a;
                        sb_reg     <= b;
                        borrow_reg <= 1'b0;
                        cnt_reg    <= '0;
                        // Operand MSBs are kept aside because the shift registers lose them.
                        a_msb_reg  <= a[WIDTH-1];
                        b_msb_reg  <= b[WIDTH-1];
                        state_reg  <= RUN;
                    end
                end
                RUN: begin
                    sa_reg     <= sa_reg >> 1;
                    sb_reg     <= sb_reg >> 1;
                    res_reg    <= res_next;
                    borrow_reg <= bout;
                    cnt_reg    <= cnt_reg + 1'b1;
                    if (cnt_reg == LAST_BIT) begin
                        dif       <= res_next;
                        br        <= bout;
                        ovf       <= (a_msb_reg != b_msb_reg) && (d != a_msb_reg);
                        state_reg <= DONE;
                    end
                end
                DONE: state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign busy = (state_reg == RUN);
    assign done = (state_reg == DONE);

endmodule

// File: tb/tb_serial_subtractor.sv
// Randomised and directed checks of serial_subtractor at WIDTH=8 and WIDTH=4
// against an arithmetic reference model.
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] a = '0, b = '0, dif;
    logic       busy, done, br, ovf;

    logic       start4 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0, dif4;
    logic       busy4, done4, br4, ovf4;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .dif(dif), .br(br), .ovf(ovf)
    );

    serial_subtractor #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .dif(dif4), .br(br4), .ovf(ovf4)
    );

    function automatic void model8(input logic [7:0] x, input logic [7:0] y,
                                   output logic [7:0] md, output logic mb, output logic mo);
        int sd;
        md = x - y;
        mb = (x < y);
        sd = int'($signed(x)) - int'($signed(y));
        mo = (sd < -128) || (sd > 127);
    endfunction

    function automatic void model4(input logic [3:0] x, input logic [3:0] y,
                                   output logic [3:0] md, output logic mb, output logic mo);
        int sd;
        md = x - y;
        mb = (x < y);
        sd = int'($signed(x)) - int'($signed(y));
        mo = (sd < -8) || (sd > 7);
    endfunction

    // Drives one operation and reports the result, latency, busy cycles and whether outputs held during RUN.
    task automatic op8(input logic [7:0] x, input logic [7:0] y,
                       output logic [7:0] od, output logic ob, output logic oo,
                       output int lat, output int nbusy, output logic held);
        logic [7:0] prev;
        @(negedge clk);
        a = x; b = y; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1; nbusy = 0; held = 1'b1; prev = dif;
        while (!done && lat < 40) begin
            if (busy) nbusy++;
            if (dif !== prev) held = 1'b0;
            @(negedge clk);
            lat++;
        end
        od = dif; ob = br; oo = ovf;
        $display("op8 a=%0d b=%0d -> dif=%0d br=%0b ovf=%0b lat=%0d", x, y, od, ob, oo, lat);
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0;
        repeat (2) @(negedge clk);
        n_vec++;
        if ({busy, done, dif, br, ovf} !== 12'd0) begin
            n_err++;
            $display("FAIL reset: busy=%0b done=%0b dif=%0d br=%0b ovf=%0b, want all 0", busy, done, dif, br, ovf);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic;
        logic [7:0] od; logic ob, oo, held; int lat, nb;
        op8(8'd100, 8'd37, od, ob, oo, lat, nb, held);
        n_vec++;
        if ({od, ob, oo} !== {8'd63, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL basic_result: dif=%0d br=%0b ovf=%0b, want 63 0 0", od, ob, oo);
        end
        n_vec++;
        if (lat !== 9) begin
            n_err++;
            $display("FAIL basic_latency: got %0d, want 9", lat);
        end
        n_vec++;
        if (nb !== 8) begin
            n_err++;
            $display("FAIL basic_busy_cycles: got %0d, want 8", nb);
        end
        n_vec++;
        if (held !== 1'b1) begin
            n_err++;
            $display("FAIL basic_hold: outputs changed during RUN, want held");
        end
    endtask

    task automatic test_boundaries;
        logic [7:0] ta [7] = '{8'd5, 8'd0, 8'h80, 8'h7F, 8'hFF, 8'd100, 8'h80};
        logic [7:0] tb [7] = '{8'd9, 8'd1, 8'h01, 8'hFF, 8'hFF, 8'd100, 8'h7F};
        logic [7:0] ed [7] = '{8'd252, 8'd255, 8'h7F, 8'h80, 8'd0, 8'd0, 8'h01};
        logic       eb [7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic       eo [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [7:0] od; logic ob, oo, held; int lat, nb;
        for (int i = 0; i < 7; i++) begin
            op8(ta[i], tb[i], od, ob, oo, lat, nb, held);
            n_vec++;
            if ({od, ob, oo, held} !== {ed[i], eb[i], eo[i], 1'b1}) begin
                n_err++;
                $display("FAIL boundary_%0d: dif=%0d br=%0b ovf=%0b held=%0b, want %0d %0b %0b 1",
                         i, od, ob, oo, held, ed[i], eb[i], eo[i]);
            end
        end
    endtask

    task automatic test_ignore_start;
        int lat;
        @(negedge clk);
        a = 8'd100; b = 8'd37; start = 1'b1;
        @(negedge clk);
        a = 8'd200; b = 8'd1;
        lat = 1;
        while (!done && lat < 40) begin @(negedge clk); lat++; end
        n_vec++;
        if (lat !== 9 || dif !== 8'd63) begin
            n_err++;
            $display("FAIL ignore_first: lat=%0d dif=%0d, want 9 63", lat, dif);
        end
        @(negedge clk);
        n_vec++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL ignore_idle: busy=%0b done=%0b, want 0 0", busy, done);
        end
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        while (!done && lat < 40) begin @(negedge clk); lat++; end
        n_vec++;
        if (lat !== 9 || dif !== 8'd199 || br !== 1'b0) begin
            n_err++;
            $display("FAIL ignore_second: lat=%0d dif=%0d br=%0b, want 9 199 0", lat, dif, br);
        end
        $display("retrigger second result dif=%0d", dif);
    endtask

    task automatic test_reset_midrun;
        logic [7:0] od; logic ob, oo, held, seen; int lat, nb;
        @(negedge clk);
        a = 8'd100; b = 8'd37; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        n_vec++;
        if ({busy, done, dif, br, ovf} !== 12'd0) begin
            n_err++;
            $display("FAIL midrun_async_reset: busy=%0b done=%0b dif=%0d br=%0b ovf=%0b, want all 0",
                     busy, done, dif, br, ovf);
        end
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        n_vec++;
        if (seen !== 1'b0) begin
            n_err++;
            $display("FAIL midrun_no_done: got done pulse, want none");
        end
        op8(8'hFF, 8'hFF, od, ob, oo, lat, nb, held);
        n_vec++;
        if ({od, ob, oo} !== 10'd0 || lat !== 9) begin
            n_err++;
            $display("FAIL after_reset: dif=%0d br=%0b ovf=%0b lat=%0d, want 0 0 0 9", od, ob, oo, lat);
        end
    endtask

    task automatic test_random;
        logic [7:0] x, y, od, md; logic ob, oo, held, mb, mo; int lat, nb;
        for (int i = 0; i < 1000; i++) begin
            x = 8'($urandom); y = 8'($urandom);
            op8(x, y, od, ob, oo, lat, nb, held);
            model8(x, y, md, mb, mo);
            n_vec++;
            if ({od, ob, oo} !== {md, mb, mo} || lat !== 9) begin
                n_err++;
                $display("FAIL random a=%0d b=%0d: dif=%0d br=%0b ovf=%0b lat=%0d, want %0d %0b %0b 9",
                         x, y, od, ob, oo, lat, md, mb, mo);
            end
        end
    endtask

    task automatic test_exhaustive4;
        logic [3:0] md; logic mb, mo; int lat;
        for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
                @(negedge clk);
                a4 = 4'(x); b4 = 4'(y); start4 = 1'b1;
                @(negedge clk);
                start4 = 1'b0;
                lat = 1;
                while (!done4 && lat < 30) begin @(negedge clk); lat++; end
                model4(4'(x), 4'(y), md, mb, mo);
                $display("op4 a=%0d b=%0d -> dif=%0d br=%0b ovf=%0b lat=%0d", x, y, dif4, br4, ovf4, lat);
                n_vec++;
                if ({dif4, br4, ovf4} !== {md, mb, mo} || lat !== 5) begin
                    n_err++;
                    $display("FAIL w4 a=%0d b=%0d: dif=%0d br=%0b ovf=%0b lat=%0d, want %0d %0b %0b 5",
                             x, y, dif4, br4, ovf4, lat, md, mb, mo);
                end
            end
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_boundaries;
        test_ignore_start;
        test_reset_midrun;
        test_random;
        test_exhaustive4;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial N-bit unsigned subtractor that computes dif = a - b and a final borrow, one bit per clock, LSB first.
- Internally it chains two half-subtractor stages per bit: a-b, then minus the borrow-in.
- A borrow flip-flop carries the borrow between bit times.
- It sits downstream of the half-subtractor cell, uses that cell's dif/br equations as its per-bit datapath, and feeds wider arithmetic exercises that need a low-area subtractor.

Parameters:
- WIDTH, 8, operand and result width in bits (min 2).
- CNT_W, $clog2(WIDTH+1), bit-counter width (derived; do not override).

Ports:
- clk    input   1      rising-edge clock.
- rst    input   1      asynchronous, active-high reset.
- start  input   1      request; sampled only in IDLE.
- a      input   WIDTH  minuend; sampled on the accepting edge only.
- b      input   WIDTH  subtrahend; sampled on the accepting edge only.
- busy   output  1      high while in RUN.
- done   output  1      one-cycle pulse: result valid.
- dif    output  WIDTH  registered difference, a - b mod 2^WIDTH.
- br     output  1      registered final borrow; 1 iff a < b (unsigned).
- ovf    output  1      registered signed overflow (two's-complement view of a, b, dif).

Behaviour:
- Reset (async, any time, including mid-RUN):
  - state=IDLE; busy=0, done=0, dif=0, br=0, ovf=0.
  - Shift registers, borrow FF and counter cleared.
  - The in-flight operation is discarded; no done pulse follows.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 at an edge loads a→sa, b→sb, borrow FF=0, cnt=0; next state RUN.
  - start=0: stay in IDLE.
- RUN, per edge, bit x=sa[0], y=sb[0], bin=borrow FF:
  - Stage 1: d1 = x^y, b1 = ~x & y.
  - Stage 2: d = d1^bin, b2 = ~d1 & bin.
  - borrow FF <= b1 | b2.
  - d shifted into an internal result register from the MSB end, so after WIDTH shifts bit 0 sits at LSB.
  - sa, sb shift right one bit; cnt increments.
  - On the edge that processes bit WIDTH-1 (cnt==WIDTH-1):
    - dif <= completed result.
    - br <= b1|b2 of that bit.
    - ovf <= (a[MSB] != b[MSB]) && (dif[MSB] != a[MSB]), using the latched operand MSBs.
    - Next state DONE.
- DONE: lasts exactly one cycle, then IDLE unconditionally.
- Outputs:
  - busy = (state==RUN), done = (state==DONE); both are decoded from the state register and glitch-free.
  - dif/br/ovf hold the previous result through RUN and change only on the completing edge.
  - They then hold until the next completion or reset.
- Latency: start accepted at edge k → done high in the cycle after edge k+WIDTH. That is WIDTH+1 cycles from acceptance to done; throughput is 1 op per WIDTH+2 cycles.
- start while busy or done is ignored: no reload, no queuing, and a/b changes during RUN have no effect.
- start held high continuously re-triggers on each IDLE cycle, i.e. every WIDTH+2 cycles.
- Boundaries:
  - a==b gives dif=0, br=0.
  - 0-1 wraps to all-ones with br=1.
  - Max operands (all-ones minus all-ones) give 0, br=0.
  - Borrow ripples correctly through all WIDTH bits (e.g. 2^(WIDTH-1) - 1).

Test Plan:
- WIDTH=8, a=100, b=37, start pulse → busy high 8 cycles; done pulse 9 cycles after acceptance; dif=63, br=0, ovf=0.
- a=5, b=9 → dif=252 (0xFC), br=1, ovf=0. Then a=0, b=1 → dif=255, br=1.
- a=0x80, b=0x01 → dif=0x7F, br=0, ovf=1. Then a=0x7F, b=0xFF → dif=0x80, br=1, ovf=1.
- Start accepted with a=100, b=37; then a=200, b=1 with start=1 on every cycle of RUN and the DONE cycle → first result 63 unchanged. Next acceptance occurs only in the IDLE cycle and yields 199.
- Assert rst for one cycle during the 4th RUN cycle → outputs 0 asynchronously (before the next edge); no done pulse. The following start with a=255, b=255 → dif=0, br=0.
- Randomised sweep: 1000 random a/b with back-to-back starts; compare dif/br/ovf to a reference model after every done pulse. Repeat at WIDTH=4 exhaustively (256 pairs).
